adc_approx_ctrl: RTL and testbench

//  Digital conversion controller for the comparator/DAC converter loop.
//  It drives the DAC code from the comparator up/down outputs.

---
 rtl/adc_approx_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_adc_approx_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_approx_ctrl.sv
// Conversion controller for the comparator/DAC loop: tracking or SAR mode, settle delay, start/valid.
// Define ADC_OVERRANGE_EN to add the sticky over-range output ovr.
module adc_approx_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 4,
  parameter int STEP   = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             mode,
  input  logic             start,
  input  logic             abort,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy,
  output logic             lock,
`ifdef ADC_OVERRANGE_EN
  output logic             ovr,
`endif
  output logic [2:0]       dbg_state
);

  // Handshake: start is taken only on an edge where the block is IDLE (busy=0) and abort=0;
  // valid is a one-cycle pulse, coincident with the new result, that needs no acknowledge.

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SAR_WAIT   = 3'd1,
    SAR_DECIDE = 3'd2,
    TRK_WAIT   = 3'd3,
    TRK_DECIDE = 3'd4
  } state_t;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int IW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MAX_CODE  = '1;
  localparam logic [WIDTH-1:0] MID_CODE  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_CODE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   STEP_X    = (WIDTH+1)'(STEP);
  localparam logic [CW-1:0]    WAIT_LOAD = CW'(SETTLE - 1);
  localparam logic [CW-1:0]    WAIT_ONE  = CW'(1);
  localparam logic [IW-1:0]    TOP_BIT   = IW'(WIDTH - 1);
  localparam logic [IW-1:0]    BIT_ONE   = IW'(1);

  state_t           r_state, w_state_nx;
  logic [CW-1:0]    r_wait, w_wait_nx;
  logic [IW-1:0]    r_bit, w_bit_nx;
  logic [WIDTH-1:0] r_count, w_count_nx;
  logic [WIDTH-1:0] r_result, w_result_nx;
  logic             r_valid, w_valid_nx;
  logic             r_lock, w_lock_nx;
`ifdef ADC_OVERRANGE_EN
  logic             r_ovr, w_ovr_nx;
`endif

  logic             w_higher, w_lower, w_hold;
  logic [WIDTH-1:0] w_mask, w_sar_code, w_trk_code;
  logic [WIDTH:0]   w_sum, w_dif;

  assign w_higher = up & ~down;
  assign w_lower  = down & ~up;
  assign w_hold   = ~(w_higher | w_lower);

  // SAR: a lower decision clears the bit under test, anything else keeps it.
  assign w_mask     = ONE_CODE << r_bit;
  assign w_sar_code = w_lower ? (r_count & ~w_mask) : r_count;

  // Tracking math one bit wider so the carry/borrow selects the clamp value.
  assign w_sum = {1'b0, r_count} + STEP_X;
  assign w_dif = {1'b0, r_count} - STEP_X;
  assign w_trk_code = w_higher ? (w_sum[WIDTH] ? MAX_CODE : w_sum[WIDTH-1:0]) :
                      w_lower  ? (w_dif[WIDTH] ? '0       : w_dif[WIDTH-1:0]) :
                                 r_count;

  always_comb begin
    w_state_nx  = r_state;
    w_wait_nx   = r_wait;
    w_bit_nx    = r_bit;
    w_count_nx  = r_count;
    w_result_nx = r_result;
    w_valid_nx  = 1'b0;
    w_lock_nx   = r_lock;
`ifdef ADC_OVERRANGE_EN
    w_ovr_nx    = r_ovr;
`endif
    if (abort) begin
      w_state_nx = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_wait_nx = WAIT_LOAD;
`ifdef ADC_OVERRANGE_EN
            w_ovr_nx  = 1'b0;
`endif
            if (mode) begin
              w_count_nx = MID_CODE;
              w_bit_nx   = TOP_BIT;
              w_state_nx = SAR_WAIT;
            end else begin
              w_state_nx = TRK_WAIT;
            end
          end
        end
        SAR_WAIT, TRK_WAIT: begin
          if (r_wait == '0) begin
            w_state_nx = (r_state == SAR_WAIT) ? SAR_DECIDE : TRK_DECIDE;
          end else begin
            w_wait_nx = r_wait - WAIT_ONE;
          end
        end
        SAR_DECIDE: begin
          w_wait_nx = WAIT_LOAD;
          if (r_bit != '0) begin
            w_count_nx = w_sar_code | (w_mask >> 1);
            w_bit_nx   = r_bit - BIT_ONE;
            w_state_nx = SAR_WAIT;
          end else begin
            w_count_nx  = w_sar_code;
            w_result_nx = w_sar_code;
            w_valid_nx  = 1'b1;
            w_state_nx  = IDLE;
`ifdef ADC_OVERRANGE_EN
            if ((w_higher && w_sar_code == MAX_CODE) || (w_lower && w_sar_code == '0))
              w_ovr_nx = 1'b1;
`endif
          end
        end
        TRK_DECIDE: begin
          w_wait_nx   = WAIT_LOAD;
          w_count_nx  = w_trk_code;
          w_result_nx = w_trk_code;
          w_valid_nx  = 1'b1;
          w_lock_nx   = w_hold;
          w_state_nx  = TRK_WAIT;
`ifdef ADC_OVERRANGE_EN
          if ((w_higher && r_count == MAX_CODE) || (w_lower && r_count == '0))
            w_ovr_nx = 1'b1;
`endif
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state  <= IDLE;
      r_wait   <= '0;
      r_bit    <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_lock   <= 1'b0;
`ifdef ADC_OVERRANGE_EN
      r_ovr    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nx;
      r_wait   <= w_wait_nx;
      r_bit    <= w_bit_nx;
      r_count  <= w_count_nx;
      r_result <= w_result_nx;
      r_valid  <= w_valid_nx;
      r_lock   <= w_lock_nx;
`ifdef ADC_OVERRANGE_EN
      r_ovr    <= w_ovr_nx;
`endif
    end
  end

  assign count     = r_count;
  assign result    = r_result;
  assign valid     = r_valid;
  assign busy      = (r_state != IDLE);
  assign lock      = r_lock;
  assign dbg_state = r_state;
`ifdef ADC_OVERRANGE_EN
  assign ovr       = r_ovr;
`endif

endmodule

// File: tb/tb_adc_approx_ctrl.sv
// Bench for adc_approx_ctrl (WIDTH=8, SETTLE=4, STEP=1): SAR vector table, tracking model, corner sequences.
module tb_adc_approx_ctrl;

  localparam int W      = 8;
  localparam int SETTLE = 4;
  localparam int STEP   = 1;
  localparam int P      = SETTLE + 1;
  localparam int LAT    = W * P;
  localparam int MAXV   = (1 << W) - 1;

  logic         clock, clear, mode, start, abort, up, down;
  logic [W-1:0] count, result;
  logic         valid, busy, lock;
  logic [2:0]   dbg_state;
`ifdef ADC_OVERRANGE_EN
  logic         ovr;
`endif

  adc_approx_ctrl #(.WIDTH(W), .SETTLE(SETTLE), .STEP(STEP)) dut (
    .clock(clock), .clear(clear), .mode(mode), .start(start), .abort(abort),
    .up(up), .down(down), .count(count), .result(result), .valid(valid),
    .busy(busy), .lock(lock),
`ifdef ADC_OVERRANGE_EN
    .ovr(ovr),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- comparator model ----------------
  // cmp_sel: 0 ideal comparator against tgt_r, 1 up held, 2 down held, 3 both high
  int         cmp_sel;
  logic [W-1:0] tgt_r;
  always_comb begin
    up   = 1'b0;
    down = 1'b0;
    case (cmp_sel)
      0: begin up = (tgt_r > count); down = (tgt_r < count); end
      1: up = 1'b1;
      2: down = 1'b1;
      default: begin up = 1'b1; down = 1'b1; end
    endcase
  end

  function automatic bit f_higher(input int cm, input int t, input int c);
    if (cm == 0) return (t > c);
    return (cm == 1);
  endfunction

  function automatic bit f_lower(input int cm, input int t, input int c);
    if (cm == 0) return (t < c);
    return (cm == 2);
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  int m_count = 0;
  int m_lock  = 0;
  int m_ovr   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (clear && valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got result 0x%0h, expected no pulse at %0t", result, $time);
      end else begin
        check("result", 32'(result), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_conv(input logic m);
    @(negedge clock);
    mode  = m;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    mode  = 1'($urandom_range(0, 1));
  endtask

  task automatic do_abort();
    @(negedge clock);
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    @(negedge clock);
    check("abort_busy", 32'(busy), 0);
    check("abort_count", 32'(count), m_count);
    check("abort_lock", 32'(lock), m_lock);
  endtask

  task automatic run_sar(input int t, input int cm, input bit glitch, input int exp_res, input int exp_ovr);
    int acc, trial, bi;
    bit got;
    tgt_r   = W'(t);
    cmp_sel = cm;
    exp_q.push_back(W'(exp_res));
    start_conv(1'b1);
    m_ovr = 0;
    acc   = 0;
    got   = 1'b0;
    for (int e = 0; e < LAT + 20 && !got; e++) begin
      @(negedge clock);
      if (e < LAT && e % P == 0) begin
        bi    = W - 1 - e / P;
        trial = acc | (1 << bi);
        check("sar_count_trace", 32'(count), trial);
        check("sar_busy", 32'(busy), 1);
        if (!f_lower(cm, t, trial)) acc = trial;
        if (bi == 0)
          m_ovr = ((acc == MAXV && f_higher(cm, t, trial)) || (acc == 0 && f_lower(cm, t, trial))) ? 1 : 0;
      end
      if (glitch) begin
        if (e == 12) begin start = 1'b1; mode = 1'b0; end
        else if (e == 13) start = 1'b0;
      end
      if (valid) begin
        got = 1'b1;
        check("sar_latency", e, LAT);
        check("sar_busy_done", 32'(busy), 0);
        check("sar_final_count", 32'(count), acc);
        check("sar_model_vs_table", acc, exp_res);
`ifdef ADC_OVERRANGE_EN
        check("sar_ovr", 32'(ovr), exp_ovr);
        check("sar_ovr_model", m_ovr, exp_ovr);
`endif
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL sar_timeout: got no valid, expected valid after %0d edges", LAT);
      void'(exp_q.pop_back());
    end
    m_count = acc;
    @(negedge clock);
    check("sar_idle_after", 32'(busy), 0);
    check("sar_state_idle", 32'(dbg_state), 0);
    check("sar_no_second_valid", 32'(valid), 0);
  endtask

  task automatic run_track(input int n, input int t, input int cm, input bit rnd);
    bit h, l;
    tgt_r   = W'(t);
    cmp_sel = cm;
    start_conv(1'b0);
    m_ovr = 0;
    for (int e = 0; e <= n * P; e++) begin
      @(negedge clock);
      check("trk_busy", 32'(busy), 1);
      if (e > 0 && e % P == 0) begin
        check("trk_valid", 32'(valid), 1);
        check("trk_count", 32'(count), m_count);
        check("trk_lock", 32'(lock), m_lock);
`ifdef ADC_OVERRANGE_EN
        check("trk_ovr", 32'(ovr), m_ovr);
`endif
        if (rnd) begin
          cmp_sel = $urandom_range(0, 3);
          tgt_r   = W'($urandom_range(0, MAXV));
        end
      end else begin
        check("trk_valid_gap", 32'(valid), 0);
      end
      if (e % P == P - 1 && e < n * P) begin
        h = f_higher(cmp_sel, int'(tgt_r), m_count);
        l = f_lower(cmp_sel, int'(tgt_r), m_count);
        m_lock = (h || l) ? 0 : 1;
        if (h) begin
          if (m_count == MAXV) m_ovr = 1;
          m_count = (m_count + STEP > MAXV) ? MAXV : m_count + STEP;
        end else if (l) begin
          if (m_count == 0) m_ovr = 1;
          m_count = (m_count - STEP < 0) ? 0 : m_count - STEP;
        end
        exp_q.push_back(W'(m_count));
      end
    end
    do_abort();
  endtask

  // ---------------- test ----------------
  typedef struct {
    int tgt;
    int cm;
    bit glitch;
    int res;
    int ovr;
  } sar_vec_t;

  sar_vec_t sar_tab[7];

  initial begin
    int t;
    sar_tab[0] = '{tgt: 'h5A, cm: 0, glitch: 1'b0, res: 'h5A, ovr: 0};
    sar_tab[1] = '{tgt: 'hFF, cm: 0, glitch: 1'b0, res: 'hFF, ovr: 0};
    sar_tab[2] = '{tgt: 'h00, cm: 0, glitch: 1'b0, res: 'h00, ovr: 1};
    sar_tab[3] = '{tgt: 'h80, cm: 0, glitch: 1'b0, res: 'h80, ovr: 0};
    sar_tab[4] = '{tgt: 'h01, cm: 0, glitch: 1'b0, res: 'h01, ovr: 0};
    sar_tab[5] = '{tgt: 'h33, cm: 3, glitch: 1'b0, res: 'hFF, ovr: 0};
    sar_tab[6] = '{tgt: 'hC7, cm: 0, glitch: 1'b1, res: 'hC7, ovr: 0};

    clear = 1'b0; mode = 1'b0; start = 1'b0; abort = 1'b0;
    cmp_sel = 0; tgt_r = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_count", 32'(count), 0);
    check("rst_result", 32'(result), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_lock", 32'(lock), 0);
    check("rst_state", 32'(dbg_state), 0);
`ifdef ADC_OVERRANGE_EN
    check("rst_ovr", 32'(ovr), 0);
`endif
    clear = 1'b1;

    // tracking from 0 toward 0x05, then lock
    run_track(8, 'h05, 0, 1'b0);

    foreach (sar_tab[i])
      run_sar(sar_tab[i].tgt, sar_tab[i].cm, sar_tab[i].glitch, sar_tab[i].res, sar_tab[i].ovr);

    // saturation at both ends
    run_sar('h10, 1, 1'b0, 'hFF, 1);
    run_track(3, 0, 1, 1'b0);
    run_sar('h10, 2, 1'b0, 'h00, 1);
    run_track(3, 0, 2, 1'b0);
    run_track(3, 0, 3, 1'b0);

    // abort during SAR bit 3, and abort beating a simultaneous start in IDLE
    tgt_r = 8'h5A;
    cmp_sel = 0;
    start_conv(1'b1);
    for (int e = 0; e <= 24; e++) begin
      @(negedge clock);
      if (e == 20) check("abort_pre_count", 32'(count), 'h58);
      if (e == 22) abort = 1'b1;
      if (e == 23) begin
        check("abort_sar_busy", 32'(busy), 0);
        check("abort_sar_state", 32'(dbg_state), 0);
        check("abort_sar_count", 32'(count), 'h58);
        check("abort_sar_lock", 32'(lock), m_lock);
        start = 1'b1;
        mode  = 1'b1;
      end
      if (e == 24) begin
        check("abort_prio_busy", 32'(busy), 0);
        check("abort_prio_count", 32'(count), 'h58);
        abort = 1'b0;
        start = 1'b0;
      end
    end
    m_count = 'h58;
    repeat (50) begin
      @(negedge clock);
      check("abort_no_valid", 32'(valid), 0);
    end

    // clear in the middle of a SAR conversion
    start_conv(1'b1);
    repeat (17) @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    check("clr_count", 32'(count), 0);
    check("clr_result", 32'(result), 0);
    check("clr_valid", 32'(valid), 0);
    check("clr_busy", 32'(busy), 0);
    check("clr_lock", 32'(lock), 0);
`ifdef ADC_OVERRANGE_EN
    check("clr_ovr", 32'(ovr), 0);
`endif
    clear = 1'b1;
    m_count = 0; m_lock = 0; m_ovr = 0;

    // randomized conversions against the model
    for (int k = 0; k < 6; k++) begin
      t = $urandom_range(0, MAXV);
      run_sar(t, 0, 1'b0, t, (t == 0) ? 1 : 0);
    end
    run_track(20, $urandom_range(0, MAXV), 0, 1'b1);
    run_track(12, $urandom_range(0, MAXV), $urandom_range(0, 3), 1'b1);

    repeat (3) @(negedge clock);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
